// File: rtl/ucsbece154b_perfmon.sv
// ucsbece154b_perfmon: superscalar pipeline performance monitor.
// Counts run cycles, retired-looking instructions, branches/jumps and their
// mispredictions across NSLOT issue slots, and detects halt (idle spin) and
// cycle-budget timeout.
module ucsbece154b_perfmon #(
    parameter int NSLOT       = 2,
    parameter int CW          = 32,
    parameter int SAT         = 0,
    parameter int HALT_CYCLES = 2,
    parameter int MAX_CYCLES  = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic [NSLOT-1:0]      valid_i,
    input  logic [32*NSLOT-1:0]   instr_i,
    input  logic [32*NSLOT-1:0]   pc_i,
    input  logic [NSLOT-1:0]      is_branch_i,
    input  logic [NSLOT-1:0]      is_jump_i,
    input  logic [NSLOT-1:0]      miss_i,
    input  logic [2:0]            sel_i,
    output logic [CW-1:0]         rdata_o,
    output logic [1:0]            state_o,
    output logic                  overflow_o
);

    localparam int IW = $clog2(NSLOT + 1);
    // The budget counter is kept separately from the cycles counter so that a
    // narrow, wrapping cycles counter still times out at the true cycle count.
    localparam int BW = $clog2(MAX_CYCLES + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int C_CYC  = 0;
    localparam int C_INS  = 1;
    localparam int C_BR   = 2;
    localparam int C_BRM  = 3;
    localparam int C_JMP  = 4;
    localparam int C_JMM  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt      [0:5];
    logic [CW-1:0]         cnt_next [0:5];
    logic [IW-1:0]         inc      [0:5];
    logic [5:0]            carry;
    logic [7:0]            idle_run;
    logic [7:0]            idle_next;
    logic [BW-1:0]         budget;
    logic [BW-1:0]         budget_next;
    logic [32*NSLOT-1:0]   prev_pc;
    logic                  idle;
    logic                  overflow;
    logic                  halt_hit;
    logic                  timeout_hit;

    // Per-cycle increments from the slot inputs plus the idle-cycle detection.
    always_comb begin
        for (int i = 0; i < 6; i++) inc[i] = '0;
        inc[C_CYC] = IW'(1);
        idle = 1'b1;
        for (int k = 0; k < NSLOT; k++) begin
            if (valid_i[k] && instr_i[32*k +: 32] != 32'h0 && instr_i[32*k +: 32] != NOP)
                inc[C_INS] = inc[C_INS] + IW'(1);
            if (is_branch_i[k])              inc[C_BR]  = inc[C_BR]  + IW'(1);
            if (is_branch_i[k] && miss_i[k]) inc[C_BRM] = inc[C_BRM] + IW'(1);
            if (is_jump_i[k])                inc[C_JMP] = inc[C_JMP] + IW'(1);
            if (is_jump_i[k] && miss_i[k])   inc[C_JMM] = inc[C_JMM] + IW'(1);
            if (pc_i[32*k +: 32] != prev_pc[32*k +: 32] || instr_i[32*k +: 32] != NOP)
                idle = 1'b0;
        end
    end

    // Candidate counter values with wrap or saturate on carry-out.
    always_comb begin
        logic [CW:0] sum;
        for (int i = 0; i < 6; i++) begin
            sum = {1'b0, cnt[i]} + (CW+1)'(inc[i]);
            carry[i] = sum[CW];
            if (sum[CW] && SAT != 0) cnt_next[i] = '1;
            else                     cnt_next[i] = sum[CW-1:0];
        end
        idle_next   = idle ? ((idle_run == 8'hFF) ? 8'hFF : idle_run + 8'd1) : 8'd0;
        budget_next = budget + BW'(1);
        halt_hit    = (idle_next == 8'(HALT_CYCLES));
        timeout_hit = (budget_next == BW'(MAX_CYCLES));
    end

    // Previous-cycle PC capture runs in every state and ignores clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_pc <= '1;
        else       prev_pc <= pc_i;
    end

    // Main FSM: counting in RUN, halt/timeout detection, clear and hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idle_run <= '0;
            budget   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else if (clear_i) begin
            state    <= IDLE;
            idle_run <= '0;
            budget   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i) state <= RUN;
                end
                RUN: begin
                    for (int i = 0; i < 6; i++) cnt[i] <= cnt_next[i];
                    overflow <= overflow | (|carry);
                    idle_run <= idle_next;
                    budget   <= budget_next;
                    if (halt_hit)         state <= HALTED;
                    else if (timeout_hit) state <= TIMEOUT;
                    else if (!en_i)       state <= IDLE;
                end
                default: ;
            endcase
        end
    end

    assign state_o    = state;
    assign overflow_o = overflow;

    // Combinational readout mux.
    always_comb begin
        rdata_o = '0;
        case (sel_i)
            3'd0: rdata_o = cnt[C_CYC];
            3'd1: rdata_o = cnt[C_INS];
            3'd2: rdata_o = cnt[C_BR];
            3'd3: rdata_o = cnt[C_BRM];
            3'd4: rdata_o = cnt[C_JMP];
            3'd5: rdata_o = cnt[C_JMM];
            3'd6: rdata_o[2:0] = {overflow, state};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_ucsbece154b_perfmon.sv
// Testbench for ucsbece154b_perfmon: table-driven counting vectors on the
// default instance plus hand sequences for halt, reset, overflow and timeout
// on narrow wrapping and saturating instances.
module tb_ucsbece154b_perfmon;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0050_0093;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_i, clear_i;
    logic [1:0]  valid_i, is_branch_i, is_jump_i, miss_i;
    logic [63:0] instr_i, pc_i;
    logic [2:0]  sel_i;
    logic [31:0] rdata_main;
    logic [7:0]  rdata_w, rdata_s;
    logic [1:0]  state_main, state_w, state_s;
    logic        ovf_main, ovf_w, ovf_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ucsbece154b_perfmon dut (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .is_branch_i(is_branch_i), .is_jump_i(is_jump_i), .miss_i(miss_i),
        .sel_i(sel_i), .rdata_o(rdata_main), .state_o(state_main), .overflow_o(ovf_main)
    );

    ucsbece154b_perfmon #(.CW(8), .SAT(0), .MAX_CYCLES(300)) dut_wrap (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .is_branch_i(is_branch_i), .is_jump_i(is_jump_i), .miss_i(miss_i),
        .sel_i(sel_i), .rdata_o(rdata_w), .state_o(state_w), .overflow_o(ovf_w)
    );

    ucsbece154b_perfmon #(.CW(8), .SAT(1), .MAX_CYCLES(300)) dut_sat (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .is_branch_i(is_branch_i), .is_jump_i(is_jump_i), .miss_i(miss_i),
        .sel_i(sel_i), .rdata_o(rdata_s), .state_o(state_s), .overflow_o(ovf_s)
    );

    typedef struct {
        logic        en, clear;
        logic [1:0]  valid;
        logic [31:0] i0, i1;
        logic [1:0]  isb, isj, miss;
        logic [31:0] e_cyc, e_ins, e_br, e_brm, e_jmp, e_jmm;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic en, input logic clear, input logic [1:0] valid,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [1:0] isb, input logic [1:0] isj, input logic [1:0] miss,
                                input int cyc, input int ins, input int br, input int brm,
                                input int jmp, input int jmm, input logic [1:0] st);
        vec_t v;
        v.en = en; v.clear = clear; v.valid = valid; v.i0 = i0; v.i1 = i1;
        v.isb = isb; v.isj = isj; v.miss = miss;
        v.e_cyc = cyc; v.e_ins = ins; v.e_br = br; v.e_brm = brm;
        v.e_jmp = jmp; v.e_jmm = jmm; v.e_state = st;
        return v;
    endfunction

    // Drive one cycle of inputs, take the edge, and settle just after it.
    task automatic applyStimulus(input logic en, input logic clear, input logic [1:0] valid,
                                 input logic [31:0] i0, input logic [31:0] i1,
                                 input logic [31:0] pc0, input logic [31:0] pc1,
                                 input logic [1:0] isb, input logic [1:0] isj, input logic [1:0] miss);
        en_i = en; clear_i = clear; valid_i = valid;
        instr_i = {i1, i0}; pc_i = {pc1, pc0};
        is_branch_i = isb; is_jump_i = isj; miss_i = miss;
        @(posedge clk);
        #1;
    endtask

    // Select a readout on one instance and compare it with the expected value.
    task automatic checkOutput(input string name, input int which, input logic [2:0] s,
                               input logic [63:0] exp);
        logic [63:0] got;
        sel_i = s;
        #1;
        case (which)
            0:       got = 64'(rdata_main);
            1:       got = 64'(rdata_w);
            default: got = 64'(rdata_s);
        endcase
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        // Table of single-cycle vectors with hand-computed running totals.
        vecs[0] = mk(1, 0, 2'b11, ADDI, ADDI, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'd1);
        for (int i = 1; i <= 10; i++)
            vecs[i] = mk(1, 0, 2'b11, ADDI, ADDI, 2'b00, 2'b00, 2'b00, i, 2*i, 0, 0, 0, 0, 2'd1);
        vecs[11] = mk(1, 0, 2'b01, NOP, ADDI, 2'b00, 2'b00, 2'b00, 11, 20, 0, 0, 0, 0, 2'd1);
        vecs[12] = mk(1, 0, 2'b11, 32'h0, ADDI, 2'b00, 2'b00, 2'b00, 12, 21, 0, 0, 0, 0, 2'd1);
        for (int k = 1; k <= 4; k++)
            vecs[12+k] = mk(1, 0, 2'b00, ADDI, ADDI, 2'b11, 2'b00, 2'b01, 12+k, 21, 2*k, k, 0, 0, 2'd1);
        for (int k = 1; k <= 3; k++)
            vecs[16+k] = mk(1, 0, 2'b00, ADDI, ADDI, 2'b00, 2'b10, 2'b10, 16+k, 21, 8, 4, k, k, 2'd1);
        vecs[20] = mk(1, 0, 2'b00, ADDI, ADDI, 2'b10, 2'b01, 2'b11, 20, 21, 9, 5, 4, 4, 2'd1);
        vecs[21] = mk(0, 0, 2'b00, ADDI, ADDI, 2'b00, 2'b00, 2'b00, 21, 21, 9, 5, 4, 4, 2'd0);
        vecs[22] = mk(0, 0, 2'b00, ADDI, ADDI, 2'b00, 2'b00, 2'b00, 21, 21, 9, 5, 4, 4, 2'd0);
        vecs[23] = mk(1, 1, 2'b11, ADDI, ADDI, 2'b11, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 2'd0);

        reset = 1'b1; en_i = 0; clear_i = 0; valid_i = 0; instr_i = '0; pc_i = '0;
        is_branch_i = 0; is_jump_i = 0; miss_i = 0; sel_i = 0;
        #2;
        checkOutput("reset_cycles", 0, 3'd0, 0);
        checkOutput("reset_status", 0, 3'd6, 0);
        checkOutput("reset_status_wrap", 1, 3'd6, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i].en, vecs[i].clear, vecs[i].valid, vecs[i].i0, vecs[i].i1,
                          32'h1000 + 32'(i*8), 32'h1004 + 32'(i*8),
                          vecs[i].isb, vecs[i].isj, vecs[i].miss);
            checkOutput($sformatf("vec%0d_cycles", i),   0, 3'd0, 64'(vecs[i].e_cyc));
            checkOutput($sformatf("vec%0d_instrs", i),   0, 3'd1, 64'(vecs[i].e_ins));
            checkOutput($sformatf("vec%0d_branches", i), 0, 3'd2, 64'(vecs[i].e_br));
            checkOutput($sformatf("vec%0d_br_miss", i),  0, 3'd3, 64'(vecs[i].e_brm));
            checkOutput($sformatf("vec%0d_jumps", i),    0, 3'd4, 64'(vecs[i].e_jmp));
            checkOutput($sformatf("vec%0d_jmp_miss", i), 0, 3'd5, 64'(vecs[i].e_jmm));
            checkOutput($sformatf("vec%0d_status", i),   0, 3'd6, 64'(vecs[i].e_state));
        end
        checkOutput("sel7_zero", 0, 3'd7, 0);

        // Halt: fixed PCs with NOPs; first edge only enters RUN.
        applyStimulus(1, 0, 2'b11, NOP, NOP, 32'h40, 32'h44, 0, 0, 0);
        applyStimulus(1, 0, 2'b11, NOP, NOP, 32'h40, 32'h44, 0, 0, 0);
        checkOutput("halt_idle1_status", 0, 3'd6, 1);
        checkOutput("halt_idle1_cycles", 0, 3'd0, 1);
        applyStimulus(1, 0, 2'b11, NOP, NOP, 32'h40, 32'h44, 0, 0, 0);
        checkOutput("halt_idle2_status", 0, 3'd6, 2);
        checkOutput("halt_idle2_cycles", 0, 3'd0, 2);
        for (int n = 0; n < 3; n++)
            applyStimulus(1, 0, 2'b11, ADDI, ADDI, 32'h200 + 32'(n*8), 32'h204 + 32'(n*8), 2'b11, 0, 0);
        checkOutput("halt_frozen_status", 0, 3'd6, 2);
        checkOutput("halt_frozen_cycles", 0, 3'd0, 2);
        checkOutput("halt_frozen_instrs", 0, 3'd1, 0);
        checkOutput("halt_frozen_branches", 0, 3'd2, 0);
        applyStimulus(1, 1, 2'b11, ADDI, ADDI, 32'h300, 32'h304, 0, 0, 0);
        checkOutput("halt_clear_status", 0, 3'd6, 0);
        checkOutput("halt_clear_cycles", 0, 3'd0, 0);

        // Asynchronous reset in the middle of RUN.
        for (int n = 0; n < 4; n++)
            applyStimulus(1, 0, 2'b11, ADDI, ADDI, 32'h400 + 32'(n*8), 32'h404 + 32'(n*8), 0, 0, 0);
        checkOutput("prereset_cycles", 0, 3'd0, 3);
        reset = 1'b1;
        checkOutput("async_reset_cycles", 0, 3'd0, 0);
        checkOutput("async_reset_instrs", 0, 3'd1, 0);
        checkOutput("async_reset_status", 0, 3'd6, 0);
        applyStimulus(1, 0, 2'b11, ADDI, ADDI, 32'h500, 32'h504, 0, 0, 0);
        checkOutput("held_reset_status", 0, 3'd6, 0);
        reset = 1'b0;
        applyStimulus(1, 0, 2'b11, ADDI, ADDI, 32'h508, 32'h50C, 0, 0, 0);
        checkOutput("post_reset_status", 0, 3'd6, 1);
        checkOutput("post_reset_cycles", 0, 3'd0, 0);

        // Overflow and timeout on the narrow instances.
        applyStimulus(1, 1, 2'b11, ADDI, ADDI, 32'h600, 32'h604, 0, 0, 0);
        checkOutput("ovf_clear_status_wrap", 1, 3'd6, 0);
        applyStimulus(1, 0, 2'b11, ADDI, ADDI, 32'h608, 32'h60C, 0, 0, 0);
        for (int n = 1; n <= 301; n++) begin
            applyStimulus(1, 0, 2'b11, ADDI, ADDI, 32'h1_0000 + 32'(n*8), 32'h1_0004 + 32'(n*8), 0, 0, 0);
            if (n == 127) begin
                checkOutput("wrap_instrs_127", 1, 3'd1, 254);
                checkOutput("wrap_status_127", 1, 3'd6, 1);
            end
            if (n == 128) begin
                checkOutput("wrap_instrs_128", 1, 3'd1, 0);
                checkOutput("wrap_status_128", 1, 3'd6, 5);
                checkOutput("sat_instrs_128", 2, 3'd1, 255);
                checkOutput("sat_status_128", 2, 3'd6, 5);
            end
            if (n == 299) checkOutput("wrap_status_299", 1, 3'd6, 5);
            if (n == 300) begin
                checkOutput("wrap_status_300", 1, 3'd6, 7);
                checkOutput("main_cycles_300", 0, 3'd0, 300);
                checkOutput("main_status_300", 0, 3'd6, 1);
            end
        end
        checkOutput("wrap_timeout_held", 1, 3'd6, 7);
        checkOutput("wrap_cycles_frozen", 1, 3'd0, 44);
        checkOutput("wrap_instrs_frozen", 1, 3'd1, 88);
        checkOutput("sat_instrs_frozen", 2, 3'd1, 255);
        checkOutput("sat_status_timeout", 2, 3'd6, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
